// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: bundles the program-counter sequencer's start/done handshake,
// instruction-memory port and decoder control lines.
//   master : the sequencer (drives instr_addr, instr_out, instr_valid, busy,
//            done, overrun, cycle_count)
//   slave  : surrounding top level / memory / decoder (drives start,
//            start_addr, instr_in, stall, branch_en, branch_rel,
//            branch_target, halt_req)
interface fetch_ctrl_if #(
  parameter int rom_size    = 512,
  parameter int instr_width = 9
);
  localparam int AW = $clog2(rom_size) + 1;

  logic                   start;
  logic [AW-1:0]          start_addr;
  logic [instr_width-1:0] instr_in;
  logic                   stall;
  logic                   branch_en;
  logic                   branch_rel;
  logic [AW-1:0]          branch_target;
  logic                   halt_req;
  logic [AW-1:0]          instr_addr;
  logic [instr_width-1:0] instr_out;
  logic                   instr_valid;
  logic                   busy;
  logic                   done;
  logic                   overrun;
  logic [15:0]            cycle_count;

  modport master (
    input  start, start_addr, instr_in, stall, branch_en, branch_rel,
           branch_target, halt_req,
    output instr_addr, instr_out, instr_valid, busy, done, overrun,
           cycle_count
  );

  modport slave (
    output start, start_addr, instr_in, stall, branch_en, branch_rel,
           branch_target, halt_req,
    input  instr_addr, instr_out, instr_valid, busy, done, overrun,
           cycle_count
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer for the instruction memory.
// Holds the PC (presented directly as instr_addr), advances it every RUN
// cycle, and applies stalls, branches (absolute or PC-relative) and halts
// from the decoder. Leaving the ROM address range stops execution with a
// sticky overrun flag.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : fetch_ctrl_if.master (start/start_addr, instr_in/instr_out,
//           instr_valid, decoder controls, busy/done/overrun/cycle_count)
module fetch_ctrl #(
  parameter int rom_size    = 512,
  parameter int instr_width = 9
) (
  input  logic         clk,
  input  logic         reset,
  fetch_ctrl_if.master bus
);
  localparam int AW = $clog2(rom_size) + 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(rom_size - 1);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state_p0, state_nxt;
  logic [AW-1:0] pc_p0, pc_nxt;
  logic          overrun_p0, overrun_nxt;
  logic          done_p0, done_nxt;
  logic [15:0]   cnt_p0, cnt_nxt;
  logic [AW-1:0] branch_dest;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Relative targets are signed offsets; the sum wraps modulo 2^AW.
  function automatic logic [AW-1:0] calc_dest(input logic [AW-1:0] pc,
                                               input logic [AW-1:0] tgt,
                                               input logic          rel);
    logic signed [AW-1:0] off;
    logic signed [AW-1:0] sum;
    off = signed'(tgt);
    sum = signed'(pc) + off;
    return rel ? unsigned'(sum) : tgt;
  endfunction

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_p0 <= IDLE;
    else       state_p0 <= state_nxt;
  end

  // PC, flags and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0      <= '0;
      overrun_p0 <= 1'b0;
      done_p0    <= 1'b0;
      cnt_p0     <= '0;
    end else begin
      pc_p0      <= pc_nxt;
      overrun_p0 <= overrun_nxt;
      done_p0    <= done_nxt;
      cnt_p0     <= cnt_nxt;
    end
  end

  assign branch_dest = calc_dest(pc_p0, bus.branch_target, bus.branch_rel);

  // Next-state and next-datapath logic
  always_comb begin
    state_nxt   = state_p0;
    pc_nxt      = pc_p0;
    overrun_nxt = overrun_p0;
    cnt_nxt     = cnt_p0;
    done_nxt    = 1'b0;
    case (state_p0)
      IDLE, HALT: begin
        if (bus.start) begin
          pc_nxt  = bus.start_addr;
          cnt_nxt = '0;
          if (bus.start_addr <= LAST_ADDR) begin
            state_nxt   = RUN;
            overrun_nxt = 1'b0;
          end else begin
            // Out-of-range start: report completion immediately.
            state_nxt   = HALT;
            overrun_nxt = 1'b1;
            done_nxt    = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_nxt = sat_inc(cnt_p0);
        if (bus.stall) begin
          // Stall dominates every other decoder request.
        end else if (bus.halt_req) begin
          state_nxt = HALT;
          done_nxt  = 1'b1;
        end else if (bus.branch_en) begin
          if (branch_dest <= LAST_ADDR) begin
            pc_nxt = branch_dest;
          end else begin
            state_nxt   = HALT;
            overrun_nxt = 1'b1;
            done_nxt    = 1'b1;
          end
        end else if (pc_p0 == LAST_ADDR) begin
          state_nxt   = HALT;
          overrun_nxt = 1'b1;
          done_nxt    = 1'b1;
        end else begin
          pc_nxt = pc_p0 + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.instr_addr  = pc_p0;
    bus.instr_valid = (state_p0 == RUN);
    bus.busy        = (state_p0 == RUN);
    bus.instr_out   = (state_p0 == RUN) ? bus.instr_in : {instr_width{1'b0}};
    bus.done        = done_p0;
    bus.overrun     = overrun_p0;
    bus.cycle_count = cnt_p0;
  end
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter sequencer for the instruction memory. Holds the PC, drives `instr_addr`, advances it each cycle, applies branches, stalls and halts from the decoder, and reports completion to the testbench or top level. Sits between the top-level start/done handshake, the instruction memory (`instr_addr` → `instr_out`, combinational read) and the decoder.

## Interface
Parameters:
- `rom_size`, 512, instruction memory depth; must be a power of two.
- `instr_width`, 9, instruction word width.
- AW (derived, not overridable) = $clog2(rom_size)+1, address width matching the memory's `instr_addr` port.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  begin execution at `start_addr`; honored in IDLE and HALT, ignored in RUN.
- `start_addr`  in  AW  first PC value.
- `instr_in`  in  instr_width  word read from instruction memory at `instr_addr`.
- `stall`  in  1  hold PC and instruction this cycle.
- `branch_en`  in  1  take branch this cycle.
- `branch_rel`  in  1  1 = `branch_target` is a signed two's-complement offset from PC, 0 = absolute address.
- `branch_target`  in  AW  branch address or offset.
- `halt_req`  in  1  decoder has decoded a halt instruction.
- `instr_addr`  out  AW  PC, to instruction memory.
- `instr_out`  out  instr_width  `instr_in` when `instr_valid`, else 0.
- `instr_valid`  out  1  high in RUN.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse on entry to HALT.
- `overrun`  out  1  sticky; PC left [0, rom_size-1].
- `cycle_count`  out  16  cycles spent in RUN.

## Operation
- States: IDLE (reset state), RUN, HALT.
- IDLE/HALT + `start`: PC ← `start_addr`, `overrun` ← 0, `cycle_count` ← 0, go to RUN. If `start_addr` ≥ rom_size: go to HALT instead, `overrun` ← 1, `done` pulses.
- RUN, per-cycle priority (first match wins):
  1. `stall`: PC holds; `branch_en`/`halt_req` ignored.
  2. `halt_req`: go to HALT, PC holds.
  3. `branch_en`: new = `branch_target` (abs) or PC + `branch_target` mod 2^AW (rel). If new ≥ rom_size: HALT, `overrun` ← 1, PC holds. Else PC ← new.
  4. Otherwise, if PC = rom_size-1: HALT, `overrun` ← 1, PC holds. Else PC ← PC+1.
- HALT: PC, `overrun` and `cycle_count` hold until `start`.
- `cycle_count` increments every RUN cycle, stall cycles included; saturates at 16'hFFFF.

## Timing
- Reset (async, any state, mid-run included): state IDLE, PC 0, `instr_addr` 0, `instr_out` 0, `instr_valid` 0, `busy` 0, `done` 0, `overrun` 0, `cycle_count` 0.
- `instr_addr` is the PC register. Memory read is combinational, so `instr_in` for the current PC is valid in the same cycle. Decoder inputs (`stall`, `branch_en`, `halt_req`, branch fields) are sampled at the same edge that updates PC.
- Start latency: `start` sampled at edge N; `instr_addr` = `start_addr` and `instr_valid` = 1 from edge N.
- Branch latency: a branch sampled at edge N presents its target at edge N; no delay slot.
- `done` is registered: high for exactly the one cycle after the edge that enters HALT. `busy` and `instr_valid` drop at that same edge.
- `start` in the same cycle as `done` (HALT entered the prior edge) is honored.
- `instr_out` and `instr_valid` are combinational from state and `instr_in`.

## Test plan
- Reset, then `start` with `start_addr`=0 and no decoder activity: `instr_addr` steps 0,1,2,…,511. After the edge at PC=511, HALT, `overrun`=1, `done` pulses once, `cycle_count`=512.
- `start_addr`=5, `halt_req` at PC=8: PC sequence 5,6,7,8, then HALT with PC=8, `overrun`=0, `cycle_count`=4, `done` one cycle.
- Relative branch at PC=20 with offset 10'h3FC (−4), then absolute branch to 100: next PCs 16 and 100. Absolute branch to 600 gives HALT, `overrun`=1, PC holds.
- `stall` high for 3 cycles at PC=10 with `branch_en` and `halt_req` also high: PC stays 10, `cycle_count` +3. After release with no requests, PC=11.
- Assert `reset` mid-run at PC=40: all outputs 0 immediately (asynchronous). A later `start` with `start_addr`=7 resumes at 7 with `cycle_count` cleared.
- `start` in HALT with `start_addr`=512: immediate re-HALT, `overrun`=1, `done` pulses. `start` during RUN is ignored: the PC sequence is unchanged.
